// File: rtl/grid_state_writer.sv
// Authoritative kitchen object grid plus six station cook timers.
// Display copies refresh only on the falling edge of vsync.
module grid_state_writer #(
   parameter int ROWS       = 8,
   parameter int COLS       = 13,
   parameter int NUM_TIMERS = 6
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             vsync,
   input  logic                             tick_1hz,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [3:0]                       wr_x,
   input  logic [2:0]                       wr_y,
   input  logic [3:0]                       wr_obj,
   input  logic                             tmr_start,
   input  logic [2:0]                       tmr_idx,
   input  logic [3:0]                       tmr_x,
   input  logic [2:0]                       tmr_y,
   input  logic [3:0]                       tmr_secs,
   input  logic [3:0]                       tmr_result,
   input  logic [3:0]                       rd_x,
   input  logic [2:0]                       rd_y,
   output logic [3:0]                       rd_obj,
   output logic                             wr_err,
   output logic                             expire_pulse,
   output logic [ROWS-1:0][COLS-1:0][3:0]   object_grid,
   output logic [NUM_TIMERS-1:0][3:0]       time_grid
);

   localparam logic [3:0] COLS_L = 4'(COLS);
   localparam logic [3:0] ROWS_L = 4'(ROWS);
   localparam logic [3:0] NT_L   = 4'(NUM_TIMERS);

   logic [ROWS-1:0][COLS-1:0][3:0] grid, grid_n;
   logic [NUM_TIMERS-1:0][3:0]     rem, rem_n;
   logic [NUM_TIMERS-1:0][3:0]     tx, tx_n;
   logic [NUM_TIMERS-1:0][2:0]     ty, ty_n;
   logic [NUM_TIMERS-1:0][3:0]     res, res_n;
   logic [NUM_TIMERS-1:0][3:0]     disp_n;
   logic [NUM_TIMERS-1:0]          act, act_n;
   logic [NUM_TIMERS-1:0]          pend, pend_n;
   logic                           ready_q;
   logic                           vsync_q;
   logic                           err_n;
   logic                           exp_n;
   logic                           svc_done;
   logic                           wr_ok;
   logic                           tmr_ok;
   logic                           rd_ok;

   assign wr_ready = ready_q & ~(|pend);
   assign wr_ok    = (wr_x < COLS_L) && ({1'b0, wr_y} < ROWS_L);
   assign rd_ok    = (rd_x < COLS_L) && ({1'b0, rd_y} < ROWS_L);
   assign tmr_ok   = ({1'b0, tmr_idx} < NT_L) && (tmr_x < COLS_L)
                     && ({1'b0, tmr_y} < ROWS_L);

   always_comb begin
      grid_n   = grid;
      rem_n    = rem;
      tx_n     = tx;
      ty_n     = ty;
      res_n    = res;
      act_n    = act;
      pend_n   = pend;
      err_n    = 1'b0;
      exp_n    = 1'b0;
      svc_done = 1'b0;
      disp_n   = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (tick_1hz && act[i] && !pend[i] && rem[i] != 4'd0) begin
            rem_n[i] = rem[i] - 4'd1;
            if (rem[i] == 4'd1)
               pend_n[i] = 1'b1;
         end
      end
      // lowest pending index wins the single expiry write slot
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (pend[i] && !svc_done) begin
            svc_done            = 1'b1;
            grid_n[ty[i]][tx[i]] = res[i];
            act_n[i]            = 1'b0;
            pend_n[i]           = 1'b0;
            exp_n               = 1'b1;
         end
      end
      if (wr_valid && wr_ready) begin
         if (wr_ok)
            grid_n[wr_y][wr_x] = wr_obj;
         else
            err_n = 1'b1;
      end
      if (tmr_start) begin
         if (!tmr_ok)
            err_n = 1'b1;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            if (tmr_ok && tmr_idx == 3'(i)) begin
               rem_n[i]  = tmr_secs;
               tx_n[i]   = tmr_x;
               ty_n[i]   = tmr_y;
               res_n[i]  = tmr_result;
               act_n[i]  = 1'b1;
               pend_n[i] = (tmr_secs == 4'd0);
            end
         end
      end
      for (int i = 0; i < NUM_TIMERS; i++)
         disp_n[i] = act_n[i] ? rem_n[i] : 4'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grid         <= '0;
         rem          <= '0;
         tx           <= '0;
         ty           <= '0;
         res          <= '0;
         act          <= '0;
         pend         <= '0;
         ready_q      <= 1'b0;
         vsync_q      <= 1'b0;
         rd_obj       <= 4'd0;
         wr_err       <= 1'b0;
         expire_pulse <= 1'b0;
         object_grid  <= '0;
         time_grid    <= '0;
      end else begin
         grid         <= grid_n;
         rem          <= rem_n;
         tx           <= tx_n;
         ty           <= ty_n;
         res          <= res_n;
         act          <= act_n;
         pend         <= pend_n;
         ready_q      <= 1'b1;
         vsync_q      <= vsync;
         rd_obj       <= rd_ok ? grid[rd_y][rd_x] : 4'd0;
         wr_err       <= err_n;
         expire_pulse <= exp_n;
         if (vsync_q && !vsync) begin
            object_grid <= grid_n;
            time_grid   <= disp_n;
         end
      end
   end

endmodule

// File: tb/tb_grid_state_writer.sv
// Randomized scoreboard bench for grid_state_writer.
// A spec-level model predicts every cycle's outputs; a monitor compares.
module tb_grid_state_writer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vsync = 1'b1;
   logic tick_1hz = 1'b0;
   logic wr_valid = 1'b0;
   logic wr_ready;
   logic [3:0] wr_x = '0;
   logic [2:0] wr_y = '0;
   logic [3:0] wr_obj = '0;
   logic tmr_start = 1'b0;
   logic [2:0] tmr_idx = '0;
   logic [3:0] tmr_x = '0;
   logic [2:0] tmr_y = '0;
   logic [3:0] tmr_secs = '0;
   logic [3:0] tmr_result = '0;
   logic [3:0] rd_x = '0;
   logic [2:0] rd_y = '0;
   logic [3:0] rd_obj;
   logic wr_err;
   logic expire_pulse;
   logic [7:0][12:0][3:0] object_grid;
   logic [5:0][3:0] time_grid;

   int total = 0;
   int bad = 0;

   grid_state_writer dut (
      .clock(clk), .reset(reset), .vsync(vsync), .tick_1hz(tick_1hz),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
      .wr_y(wr_y), .wr_obj(wr_obj), .tmr_start(tmr_start),
      .tmr_idx(tmr_idx), .tmr_x(tmr_x), .tmr_y(tmr_y),
      .tmr_secs(tmr_secs), .tmr_result(tmr_result), .rd_x(rd_x),
      .rd_y(rd_y), .rd_obj(rd_obj), .wr_err(wr_err),
      .expire_pulse(expire_pulse), .object_grid(object_grid),
      .time_grid(time_grid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ready;
      logic err;
      logic ex;
      logic [3:0] rd;
      logic [7:0][12:0][3:0] og;
      logic [5:0][3:0] tg;
   } exp_t;

   exp_t sb[$];

   // model state: plain arrays indexed by row/column and timer number
   int m_grid [8][13];
   int m_rem [6];
   int m_x [6];
   int m_y [6];
   int m_res [6];
   bit m_act [6];
   bit m_pend [6];
   bit m_rq;
   bit m_vq;
   logic [7:0][12:0][3:0] m_og;
   logic [5:0][3:0] m_tg;

   function automatic bit any_pend();
      for (int i = 0; i < 6; i++)
         if (m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit was_pend [6];
      bit err;
      bit can_wr;
      int svc;
      e.ready = 0; e.err = 0; e.ex = 0; e.rd = 0; e.og = '0; e.tg = '0;
      if (reset) begin
         foreach (m_grid[r, c]) m_grid[r][c] = 0;
         for (int i = 0; i < 6; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_rem[i] = 0;
         end
         m_rq = 0; m_vq = 0; m_og = '0; m_tg = '0;
      end else begin
         err = 0;
         svc = -1;
         can_wr = m_rq && !any_pend();
         if (int'(rd_x) < 13) e.rd = 4'(m_grid[rd_y][rd_x]);
         for (int i = 0; i < 6; i++) was_pend[i] = m_pend[i];
         for (int i = 5; i >= 0; i--) if (was_pend[i]) svc = i;
         if (tick_1hz)
            for (int i = 0; i < 6; i++)
               if (m_act[i] && !was_pend[i] && m_rem[i] > 0) begin
                  m_rem[i]--;
                  if (m_rem[i] == 0) m_pend[i] = 1;
               end
         if (svc >= 0) begin
            m_grid[m_y[svc]][m_x[svc]] = m_res[svc];
            m_act[svc] = 0;
            m_pend[svc] = 0;
            e.ex = 1;
         end
         if (wr_valid && can_wr) begin
            if (int'(wr_x) < 13) m_grid[wr_y][wr_x] = int'(wr_obj);
            else err = 1;
         end
         if (tmr_start) begin
            if (int'(tmr_idx) < 6 && int'(tmr_x) < 13) begin
               m_rem[tmr_idx] = int'(tmr_secs);
               m_x[tmr_idx] = int'(tmr_x);
               m_y[tmr_idx] = int'(tmr_y);
               m_res[tmr_idx] = int'(tmr_result);
               m_act[tmr_idx] = 1;
               m_pend[tmr_idx] = (tmr_secs == 0);
            end else err = 1;
         end
         m_rq = 1;
         if (m_vq && !vsync) begin
            foreach (m_grid[r, c]) m_og[r][c] = 4'(m_grid[r][c]);
            for (int i = 0; i < 6; i++)
               m_tg[i] = m_act[i] ? 4'(m_rem[i]) : 4'd0;
         end
         m_vq = vsync;
         e.ready = m_rq && !any_pend();
         e.err = err;
         e.og = m_og;
         e.tg = m_tg;
      end
      sb.push_back(e);
   end

   task automatic check(string name, logic [415:0] got, logic [415:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("wr_ready", 416'(wr_ready), 416'(e.ready));
         check("wr_err", 416'(wr_err), 416'(e.err));
         check("expire_pulse", 416'(expire_pulse), 416'(e.ex));
         check("rd_obj", 416'(rd_obj), 416'(e.rd));
         check("object_grid", 416'(object_grid), 416'(e.og));
         check("time_grid", 416'(time_grid), 416'(e.tg));
      end
   end

   task automatic idle();
      reset = 0; tick_1hz = 0; wr_valid = 0; tmr_start = 0; vsync = 1;
   endtask

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         idle();
      end
   endtask

   task automatic start_t(int idx, int x, int y, int s, int r);
      tmr_start = 1; tmr_idx = 3'(idx); tmr_x = 4'(x); tmr_y = 3'(y);
      tmr_secs = 4'(s); tmr_result = 4'(r);
   endtask

   task automatic frame();
      vsync = 0; cyc(); cyc();
   endtask

   initial begin
      bit hold;
      reset = 1;
      cyc(2);
      // write then read back, display only after vsync
      wr_valid = 1; wr_x = 3; wr_y = 2; wr_obj = 5; cyc();
      rd_x = 3; rd_y = 2; cyc(3);
      frame();
      wr_valid = 1; wr_x = 13; wr_y = 0; wr_obj = 7; cyc(3);
      // timer 2 over three ticks
      start_t(2, 4, 1, 3, 9); cyc();
      rd_x = 4; rd_y = 1;
      frame();
      for (int k = 0; k < 3; k++) begin
         tick_1hz = 1; cyc(); cyc(); frame();
      end
      cyc(2);
      // three simultaneous expiries with a held write
      start_t(0, 0, 0, 1, 1); cyc();
      start_t(1, 1, 0, 1, 2); cyc();
      start_t(5, 2, 0, 1, 3); cyc();
      tick_1hz = 1; cyc();
      for (int k = 0; k < 6; k++) begin
         wr_valid = 1; wr_x = 2; wr_y = 0; wr_obj = 4; cyc();
      end
      frame();
      // start on tick cycle, then restart
      start_t(0, 5, 5, 2, 6); tick_1hz = 1; cyc(); frame();
      start_t(0, 5, 5, 4, 6); cyc(); frame();
      // reset with pending timers and populated grid
      start_t(3, 6, 6, 0, 8); cyc();
      start_t(4, 7, 7, 0, 8); cyc();
      reset = 1; cyc(); cyc(3); frame();
      // randomized phase
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         hold = wr_valid && !wr_ready && !reset;
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 399) == 0);
         tick_1hz = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) vsync = ~vsync;
         if (!hold) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_x = 4'($urandom_range(0, 15));
            wr_y = 3'($urandom);
            wr_obj = 4'($urandom);
         end
         tmr_start = ($urandom_range(0, 5) == 0);
         tmr_idx = 3'($urandom);
         tmr_x = 4'($urandom_range(0, 14));
         tmr_y = 3'($urandom);
         tmr_secs = 4'($urandom_range(0, 4));
         tmr_result = 4'($urandom);
         rd_x = 4'($urandom_range(0, 15));
         rd_y = 3'($urandom);
      end
      cyc(3);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
